// File: rtl/rr_arbiter8_if.sv
// Handshake bundle between the requesters and the eight-way round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_arbiter8_if;
    logic [7:0] req;
    logic       done;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic [7:0] grant_onehot;
    logic       busy;
    logic       timeout;

    modport master (
        output req, done,
        input  grant_valid, grant_idx, grant_onehot, busy, timeout
    );

    modport slave (
        input  req, done,
        output grant_valid, grant_idx, grant_onehot, busy, timeout
    );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with release handshake, turnaround gap and
// optional hold timeout; the registered grant index is expanded by decoder3to8.
module decoder3to8 (
    input  logic [2:0] sel,
    output logic [7:0] y
);
    always_comb begin
        y      = '0;
        y[sel] = 1'b1;
    end
endmodule

module rr_arbiter8 #(
    parameter int unsigned HOLD_MAX   = 0,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst,
    rr_arbiter8_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_e;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);
    localparam logic [3:0]  GAP_LOAD  = 4'(GAP_CYCLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] hold_q, hold_d;
    logic [3:0]  gap_q, gap_d;
    logic        timeout_q, timeout_d;

    logic        win_found;
    logic [2:0]  win_idx;
    logic [2:0]  cand;
    logic        rel_done, rel_wd, rel_hold;
    logic [7:0]  dec_y;

    // First set request scanning upward from ptr, wrapping modulo 8.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign rel_done = bus.done;
    assign rel_wd   = !bus.req[idx_q];
    assign rel_hold = (HOLD_MAX != 0) && (hold_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        timeout_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_GRANT;
                    idx_d   = win_idx;
                    ptr_d   = win_idx + 3'd1;
                    hold_d  = '0;
                end
            end
            S_GRANT: begin
                if (rel_done || rel_wd || rel_hold) begin
                    state_d   = S_GAP;
                    gap_d     = GAP_LOAD;
                    // Timeout flags only a forced release, never a coincident normal one.
                    timeout_d = rel_hold && !rel_done && !rel_wd;
                end else begin
                    hold_d = hold_q + 16'd1;
                end
            end
            S_GAP: begin
                if (gap_q == '0) state_d = S_IDLE;
                else             gap_d   = gap_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            gap_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
            timeout_q <= timeout_d;
        end
    end

    decoder3to8 u_dec (
        .sel (idx_q),
        .y   (dec_y)
    );

    assign bus.grant_valid  = (state_q == S_GRANT);
    assign bus.grant_idx    = idx_q;
    assign bus.grant_onehot = dec_y & {8{state_q == S_GRANT}};
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.timeout      = timeout_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: three parameterisations driven by directed vectors,
// checked every cycle against a cycle-count model plus literal expectations.
module tb_rr_arbiter8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rr_arbiter8_if if0 ();
    rr_arbiter8_if if1 ();
    rr_arbiter8_if if2 ();

    rr_arbiter8 #(.HOLD_MAX(0), .GAP_CYCLES(1)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    rr_arbiter8 #(.HOLD_MAX(4), .GAP_CYCLES(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    rr_arbiter8 #(.HOLD_MAX(0), .GAP_CYCLES(3)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    // Model: phase 0 idle, 1 owning, 2 turnaround; held = cycles owned so far,
    // left = turnaround cycles still to go.
    typedef struct {
        int phase;
        int owner;
        int ptr;
        int held;
        int left;
        int to;
    } mdl_t;

    mdl_t m0, m1, m2;

    function automatic mdl_t step(mdl_t m, logic [7:0] r, logic d, logic rs, int hmax, int gcyc);
        mdl_t n;
        int   h;
        int   forced;
        n    = m;
        n.to = 0;
        if (rs) begin
            n = '{0, 0, 0, 0, 0, 0};
            return n;
        end
        case (m.phase)
            0: begin
                for (int k = 0; k < 8; k++) begin
                    if (r[(m.ptr + k) % 8]) begin
                        n.phase = 1;
                        n.owner = (m.ptr + k) % 8;
                        n.ptr   = (n.owner + 1) % 8;
                        n.held  = 0;
                        break;
                    end
                end
            end
            1: begin
                h      = m.held + 1;
                forced = (hmax != 0 && h == hmax) ? 1 : 0;
                if (d || !r[m.owner] || forced != 0) begin
                    n.phase = 2;
                    n.left  = gcyc;
                    n.to    = (forced != 0 && !d && r[m.owner]) ? 1 : 0;
                end else begin
                    n.held = h;
                end
            end
            default: begin
                n.left = m.left - 1;
                if (n.left == 0) n.phase = 0;
            end
        endcase
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic cmp_dut(input string tag, input mdl_t m, input logic gv, input logic [2:0] gi,
                           input logic [7:0] oh, input logic b, input logic t);
        int exp_oh;
        exp_oh = (m.phase == 1) ? (1 << m.owner) : 0;
        chk({tag, ".grant_valid"},  int'(gv), (m.phase == 1) ? 1 : 0);
        chk({tag, ".grant_idx"},    int'(gi), m.owner);
        chk({tag, ".grant_onehot"}, int'(oh), exp_oh);
        chk({tag, ".busy"},         int'(b),  (m.phase != 0) ? 1 : 0);
        chk({tag, ".timeout"},      int'(t),  m.to);
    endtask

    initial begin
        m0 = '{0, 0, 0, 0, 0, 0};
        m1 = m0;
        m2 = m0;
    end

    always @(posedge clk) begin
        m0 = step(m0, if0.req, if0.done, rst, 0, 1);
        m1 = step(m1, if1.req, if1.done, rst, 4, 1);
        m2 = step(m2, if2.req, if2.done, rst, 0, 3);
        #1;
        cmp_dut("u0", m0, if0.grant_valid, if0.grant_idx, if0.grant_onehot, if0.busy, if0.timeout);
        cmp_dut("u1", m1, if1.grant_valid, if1.grant_idx, if1.grant_onehot, if1.busy, if1.timeout);
        cmp_dut("u2", m2, if2.grant_valid, if2.grant_idx, if2.grant_onehot, if2.busy, if2.timeout);
    end

    function automatic logic gv(input int w);
        case (w)
            0:       return if0.grant_valid;
            1:       return if1.grant_valid;
            default: return if2.grant_valid;
        endcase
    endfunction

    function automatic int gi(input int w);
        case (w)
            0:       return int'(if0.grant_idx);
            1:       return int'(if1.grant_idx);
            default: return int'(if2.grant_idx);
        endcase
    endfunction

    task automatic wait_grant(input int w, output int idx);
        idx = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (gv(w)) begin
                idx = gi(w);
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_grant dut%0d: got no grant expected grant within 40 cycles", w);
    endtask

    task automatic pulse_done0();
        if0.done = 1'b1;
        @(negedge clk);
        if0.done = 1'b0;
    endtask

    int idx;
    int held;
    int exp_order [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

    initial begin
        if0.req = '0; if0.done = 1'b0;
        if1.req = '0; if1.done = 1'b0;
        if2.req = '0; if2.done = 1'b0;

        // Reset held with all requests up.
        if0.req = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_valid",  int'(if0.grant_valid),  0);
            chk("rst_onehot", int'(if0.grant_onehot), 0);
            chk("rst_busy",   int'(if0.busy),         0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("first_grant_valid",  int'(if0.grant_valid),  1);
        chk("first_grant_onehot", int'(if0.grant_onehot), 8'h01);

        // Fairness: 0..7 then wrap to 0.
        chk("rr_order0", int'(if0.grant_idx), exp_order[0]);
        pulse_done0();
        for (int g = 1; g < 9; g++) begin
            wait_grant(0, idx);
            chk($sformatf("rr_order%0d", g), idx, exp_order[g]);
            pulse_done0();
        end

        // Sparse 2/5, then withdraw 5 mid-grant.
        if0.req = 8'h24;
        wait_grant(0, idx); chk("sparse_a", idx, 2); pulse_done0();
        wait_grant(0, idx); chk("sparse_b", idx, 5); pulse_done0();
        wait_grant(0, idx); chk("sparse_c", idx, 2); pulse_done0();
        wait_grant(0, idx); chk("sparse_d", idx, 5);
        if0.req = 8'h04;
        @(negedge clk);
        chk("withdraw_valid",   int'(if0.grant_valid), 0);
        chk("withdraw_timeout", int'(if0.timeout),     0);
        wait_grant(0, idx); chk("after_withdraw", idx, 2);
        if0.req = 8'h00;
        @(negedge clk);

        // Hold timeout, HOLD_MAX=4.
        if1.req = 8'h08;
        wait_grant(1, idx); chk("to_idx", idx, 3);
        held = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!if1.grant_valid) break;
            held++;
        end
        chk("to_hold_len", held, 4);
        chk("to_pulse", int'(if1.timeout), 1);
        @(negedge clk);
        chk("to_pulse_width", int'(if1.timeout), 0);
        wait_grant(1, idx); chk("to_regrant", idx, 3);
        for (int c = 0; c < 3; c++) @(negedge clk);
        if1.done = 1'b1;
        @(negedge clk);
        if1.done = 1'b0;
        chk("to_done_valid",   int'(if1.grant_valid), 0);
        chk("to_done_timeout", int'(if1.timeout),     0);
        if1.req = 8'h00;

        // Turnaround gap, GAP_CYCLES=3.
        if2.req = 8'h03;
        wait_grant(2, idx); chk("gap_first", idx, 0);
        if2.done = 1'b1;
        @(negedge clk);
        if2.done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            chk($sformatf("gap_busy%0d", c),  int'(if2.busy),        1);
            chk($sformatf("gap_valid%0d", c), int'(if2.grant_valid), 0);
        end
        @(negedge clk);
        chk("gap_idle_busy", int'(if2.busy), 0);
        @(negedge clk);
        chk("gap_next_valid", int'(if2.grant_valid), 1);
        chk("gap_next_idx",   int'(if2.grant_idx),   1);
        if2.req = 8'h00;
        @(negedge clk);

        // Reset in the middle of a grant to 6.
        if0.req = 8'h40;
        wait_grant(0, idx); chk("mid_idx", idx, 6);
        rst = 1'b1;
        if0.req = 8'hC1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid",  int'(if0.grant_valid),  0);
        chk("mid_rst_idx",    int'(if0.grant_idx),    0);
        chk("mid_rst_onehot", int'(if0.grant_onehot), 0);
        chk("mid_rst_busy",   int'(if0.busy),         0);
        @(negedge clk);
        chk("post_rst_valid", int'(if0.grant_valid), 1);
        chk("post_rst_idx",   int'(if0.grant_idx),   0);
        if0.req = 8'h00;
        for (int c = 0; c < 5; c++) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1);
    end
endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-way round-robin arbiter that shares one resource between eight requesters. It produces a registered 3-bit grant index and expands it to a one-hot grant vector through an internal `decoder3to8` instance. It sits in front of any shared datapath (bus, memory port, display driver) whose select lines were previously driven by a bare 3-to-8 decode. It adds fair arbitration, a release handshake, a turnaround gap and an optional hold timeout.

## Interface
Parameters:
- `HOLD_MAX`, default 0: maximum cycles a grant may be held.
  - 0 means unlimited. Legal range 0..65535.
  - Counter width is 16 bits.
- `GAP_CYCLES`, default 1: dead cycles inserted after every release before the next grant. Legal range 1..15.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: reset is synchronous and active-high.
- `req`  in  8: request vector. Bit i = requester i wants the resource. Level-sensitive.
- `done`  in  1: the current owner releases the resource. Sampled only in GRANT.
- `grant_valid`  out  1: a grant is active.
- `grant_idx`  out  3: index of the current owner. Holds its last value when `grant_valid`=0.
- `grant_onehot`  out  8: `decoder3to8(grant_idx)` ANDed with `{8{grant_valid}}`.
- `busy`  out  1: high in GRANT and GAP states.
- `timeout`  out  1: one-cycle pulse when a grant is force-released by `HOLD_MAX`.

## Operation
- State machine: IDLE, GRANT, GAP. Encoding is free. Reset state is IDLE.
- Round-robin pointer `ptr[2:0]`, reset value 0.
  - Search order is ptr, ptr+1, … , ptr+7, all modulo 8.
  - The first set `req` bit in that order wins.
- IDLE:
  - If `req` != 0, go to GRANT.
  - Register `grant_idx` = winner, set `grant_valid`=1, set `ptr` = winner+1 mod 8 (7 wraps to 0), clear the hold counter.
  - If `req` = 0, stay in IDLE.
- GRANT: a release is triggered by any of the following, evaluated each cycle:
  - (a) `done`=1;
  - (b) `req[grant_idx]`=0, i.e. the requester withdrew;
  - (c) `HOLD_MAX`!=0 and the hold counter reaches `HOLD_MAX`-1. The counter increments every GRANT cycle.
- On release, go to GAP: `grant_valid`=0, load the gap counter with `GAP_CYCLES`-1.
- `timeout` pulses only for cause (c) alone. If (a) or (b) coincides with (c), the release counts as normal and `timeout` stays 0.
- GAP: decrement the gap counter. When it is 0, go to IDLE. Requests are ignored during GAP.
- `done` asserted outside GRANT has no effect.
- `req` changes in GRANT for non-owner bits have no effect until the next IDLE arbitration.
- Reset at any point, including mid-GRANT or mid-GAP, returns to IDLE with `ptr`=0 and both counters cleared. No `timeout` pulse is generated.

## Timing
- Reset values: `grant_valid`=0, `grant_idx`=0, `grant_onehot`=0, `busy`=0, `timeout`=0.
- Grant latency:
  - `req` seen in IDLE at edge N gives `grant_valid`=1 after edge N, i.e. one cycle.
  - Coming out of reset, the first possible grant follows the first edge with `rst`=0.
- Release latency: release condition true at edge N gives `grant_valid`=0 after edge N. `timeout` is high for exactly the cycle following edge N.
- With `HOLD_MAX`=H, a continuously held grant lasts exactly H cycles.
- Minimum spacing between grants: 1 GRANT cycle + `GAP_CYCLES` GAP cycles + 1 IDLE cycle. With defaults, back-to-back owners see `grant_valid` low for 2 cycles.
- `grant_onehot` is combinational from registered state (no extra latency) and glitch-free relative to `clk`.

## Test plan
- Reset/idle:
  - Stimulus: hold `rst` 3 cycles with `req`=8'hFF, then release.
  - Response: all outputs 0 during reset; first grant is idx 0 (`grant_onehot`=8'h01) one cycle after `rst` falls.
- Round-robin fairness:
  - Stimulus: `req`=8'hFF constant, `done` pulsed on each grant's first cycle.
  - Response: grant order 0,1,2,…,7,0 with wrap 7→0.
- Sparse and withdraw:
  - Stimulus: `req`=8'h24 (bits 2 and 5).
  - Response: grants alternate 2,5,2.
  - Stimulus: drop `req[5]` mid-grant.
  - Response: `grant_valid` falls the next cycle with no `timeout`.
- Timeout:
  - Stimulus: `HOLD_MAX`=4, `req`=8'h08 held, `done`=0.
  - Response: `grant_valid` high exactly 4 cycles, `timeout` pulses 1 cycle, regrant to idx 3 after the gap.
  - Stimulus: repeat with `done`=1 on the 4th cycle.
  - Response: `timeout` stays 0.
- Gap:
  - Stimulus: `GAP_CYCLES`=3, `req`=8'h03.
  - Response: `busy` stays high 3 cycles after each release with `grant_valid`=0; next grant goes to the other requester.
- Mid-operation reset:
  - Stimulus: assert `rst` one cycle during GRANT of idx 6.
  - Response: outputs 0 the next cycle; after reset with `req`=8'hC1 the grant goes to idx 0 (ptr back to 0).
